// File: rtl/addsub_pkg.sv
// Shared types and constants for the nibble-serial saturating add/subtract unit.
package addsub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int NIBBLE_W = 4;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/CLA_4bit.sv
// 4-bit carry-lookahead adder slice; all carries are derived directly from generate/propagate terms.
module CLA_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    always_comb begin
        p    = A ^ B;
        g    = A & B;
        c[0] = Cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        Sum  = p ^ c[3:0];
        Cout = c[4];
    end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Saturating WIDTH-bit add/subtract that reuses one CLA_4bit across the operand nibbles,
// LSB nibble first, one nibble per clock.
module nibble_serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             Z,
    output logic             V,
    output logic             N
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [WIDTH-1:0] SAT_P = (WIDTH == 16) ? WIDTH'(SAT_POS) : {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_N = (WIDTH == 16) ? WIDTH'(SAT_NEG) : {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               done_q, done_d;
    logic               z_q, z_d;
    logic               v_q, v_d;
    logic               n_q, n_d;

    logic [NIBBLE_W-1:0] cla_a, cla_b, cla_sum;
    logic                cla_cout;
    logic                last_nib;
    logic                ovf;

    assign cla_a = opa_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
    assign cla_b = opb_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];

    CLA_4bit u_cla (
        .A    (cla_a),
        .B    (cla_b),
        .Cin  (carry_q),
        .Sum  (cla_sum),
        .Cout (cla_cout)
    );

    // opB already carries the inversion for subtract, so the classic same-sign rule applies directly.
    assign last_nib = (int'(idx_q) == NIBBLES - 1);
    assign ovf      = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (cla_sum[NIBBLE_W-1] != opa_q[WIDTH-1]);

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        psum_d   = psum_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        z_d      = z_q;
        v_d      = v_q;
        n_d      = n_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    opa_d   = A;
                    opb_d   = sub ? ~B : B;
                    carry_d = sub;
                    idx_d   = '0;
                    psum_d  = '0;
                end
            end
            RUN: begin
                psum_d[int'(idx_q)*NIBBLE_W +: NIBBLE_W] = cla_sum;
                carry_d = cla_cout;
                if (last_nib) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = ovf ? (opa_q[WIDTH-1] ? SAT_N : SAT_P) : psum_d;
                    v_d      = ovf;
                    z_d      = (result_d == '0);
                    n_d      = result_d[WIDTH-1];
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            psum_q   <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            n_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            psum_q   <= psum_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
            z_q      <= z_d;
            v_q      <= v_d;
            n_q      <= n_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign Z      = z_q;
    assign V      = v_q;
    assign N      = n_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed and random checks of nibble_serial_addsub against a plain-integer saturating model.
module tb_nibble_serial_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] A;
    logic [15:0] B;
    logic        ready;
    logic        done;
    logic [15:0] result;
    logic        Z;
    logic        V;
    logic        N;

    int checks = 0;
    int errors = 0;

    logic [15:0] last_res;
    logic        last_z, last_v, last_n;

    nibble_serial_addsub #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .A      (A),
        .B      (B),
        .ready  (ready),
        .done   (done),
        .result (result),
        .Z      (Z),
        .V      (V),
        .N      (N)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Exact signed arithmetic, then clamp to the 16-bit signed range.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [15:0] r, output logic v);
        int sa, sb, full;
        sa = int'($signed(a));
        sb = int'($signed(b));
        full = s ? (sa - sb) : (sa + sb);
        v = 1'b0;
        if (full > 32767) begin
            r = 16'h7FFF; v = 1'b1;
        end else if (full < -32768) begin
            r = 16'h8000; v = 1'b1;
        end else begin
            r = full[15:0];
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input string tag);
        logic [15:0] er;
        logic        ev;
        int          w;
        int          n;
        model(a, b, s, er, ev);
        w = 0;
        while (ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        chk({31'd0, ready}, 32'd1, {tag, "_ready_before"});
        A = a; B = b; sub = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 16'($urandom); B = 16'($urandom); sub = 1'($urandom);
        chk({31'd0, ready}, 32'd0, {tag, "_ready_run"});
        chk({16'd0, result}, {16'd0, last_res}, {tag, "_result_held"});
        chk({29'd0, Z, V, N}, {29'd0, last_z, last_v, last_n}, {tag, "_flags_held"});
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        // done becomes visible after the fourth edge past acceptance
        chk(n, 32'd4, {tag, "_latency"});
        chk({16'd0, result}, {16'd0, er}, {tag, "_result"});
        chk({29'd0, Z, V, N}, {29'd0, (er == 16'h0), ev, er[15]}, {tag, "_zvn"});
        chk({31'd0, ready}, 32'd0, {tag, "_ready_done"});
        last_res = er; last_z = (er == 16'h0); last_v = ev; last_n = er[15];
        @(posedge clk); #1;
        chk({30'd0, done, ready}, 32'd1, {tag, "_done_pulse_end"});
    endtask

    initial begin
        int          nd;
        logic [15:0] er;
        logic        ev;
        logic [15:0] ra, rb;

        rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
        last_res = '0; last_z = 1'b0; last_v = 1'b0; last_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk({31'd0, ready}, 32'd1, "reset_ready");
        chk({31'd0, done}, 32'd0, "reset_done");
        chk({16'd0, result}, 32'd0, "reset_result");
        chk({29'd0, Z, V, N}, 32'd0, "reset_zvn");
        rst = 1'b0;

        run_op(16'h1234, 16'h1111, 1'b0, "add_basic");
        run_op(16'h00FF, 16'h0001, 1'b0, "carry_chain");
        run_op(16'hFFFF, 16'h0001, 1'b0, "wrap_zero");
        run_op(16'h7FFF, 16'h0001, 1'b0, "sat_pos");
        run_op(16'h8000, 16'h0001, 1'b1, "sat_neg");
        run_op(16'h0005, 16'h0005, 1'b1, "sub_zero");
        run_op(16'h0003, 16'h0005, 1'b1, "sub_neg");
        run_op(16'h8000, 16'h8000, 1'b0, "neg_neg");
        run_op(16'h0000, 16'h8000, 1'b1, "zero_minus_min");

        // starts during RUN and DONE must be dropped
        model(16'h1000, 16'h0234, 1'b0, er, ev);
        A = 16'h1000; B = 16'h0234; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nd = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) begin
                nd++;
                start = 1'b1; A = 16'h7777; B = 16'h7777; sub = 1'b0;
            end else if (i == 1) begin
                start = 1'b1; A = 16'hFFFF; B = 16'h1111; sub = 1'b1;
            end
        end
        chk(nd, 32'd1, "ignored_start_done_count");
        chk({16'd0, result}, {16'd0, er}, "ignored_start_result");
        chk({31'd0, ready}, 32'd1, "ignored_start_ready");
        last_res = er; last_z = (er == 16'h0); last_v = ev; last_n = er[15];

        // abort in the second RUN cycle
        A = 16'h7FFF; B = 16'h0001; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk({16'd0, result}, 32'd0, "abort_result");
        chk({29'd0, Z, V, N}, 32'd0, "abort_zvn");
        chk({30'd0, ready, done}, 32'd2, "abort_ready_done");
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) nd++;
        end
        chk(nd, 32'd0, "abort_no_done");
        last_res = '0; last_z = 1'b0; last_v = 1'b0; last_n = 1'b0;
        run_op(16'h4321, 16'h1234, 1'b1, "after_abort");

        for (int k = 0; k < 40; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (k % 8 == 0) ra = {1'b0, 15'($urandom)} | 16'h7000;
            if (k % 8 == 1) ra = {1'b1, 15'($urandom)} & 16'h8FFF;
            run_op(ra, rb, 1'($urandom), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
